// File: rtl/if_stage_if.sv
// Fetch-stage bundle: downstream control, instruction-memory handshake and
// the registered {valid, inst, pc} output seen by decode.
interface if_stage_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  stall_in;
  logic                  redirect_in;
  logic [DATA_WIDTH-1:0] redirect_pc_in;
  logic                  imem_req_out;
  logic [DATA_WIDTH-1:0] imem_addr_out;
  logic                  imem_gnt_in;
  logic                  imem_rvalid_in;
  logic [DATA_WIDTH-1:0] imem_rdata_in;
  logic                  if_valid_out;
  logic [DATA_WIDTH-1:0] if_inst_out;
  logic [DATA_WIDTH-1:0] if_pc_out;

  // The fetch stage itself.
  modport master (
    input  stall_in, redirect_in, redirect_pc_in,
    input  imem_gnt_in, imem_rvalid_in, imem_rdata_in,
    output imem_req_out, imem_addr_out,
    output if_valid_out, if_inst_out, if_pc_out
  );

  // Everything around it: instruction memory and the decode stage.
  modport slave (
    output stall_in, redirect_in, redirect_pc_in,
    output imem_gnt_in, imem_rvalid_in, imem_rdata_in,
    input  imem_req_out, imem_addr_out,
    input  if_valid_out, if_inst_out, if_pc_out
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, keeps a single request outstanding to
// instruction memory, and presents a registered {valid, inst, pc} to decode.
// Handles downstream stall (one-entry hold buffer) and redirect with squash
// of any in-flight fetch.
module if_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic        clk,
  input  logic        arst_n,
  if_stage_if.master  bus
);

  localparam logic [DATA_WIDTH-1:0] NOP     = DATA_WIDTH'(32'h0000_0013);
  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

  // S_REQ: request out; S_WAIT: granted, awaiting rvalid;
  // S_HOLD: response captured while stalled (hold buffer occupied).
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic                  drop_q, drop_d;
  logic [DATA_WIDTH-1:0] hold_inst_q, hold_inst_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] inst_q, inst_d;
  logic [DATA_WIDTH-1:0] opc_q, opc_d;

  // Next-state, PC, drop flag, hold buffer and output bundle.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the
    // case statements can leave one unassigned and infer a latch.
    state_d     = state_q;
    pc_d        = pc_q;
    drop_d      = drop_q;
    hold_inst_d = hold_inst_q;
    valid_d     = valid_q;
    inst_d      = inst_q;
    opc_d       = opc_q;

    if (bus.redirect_in) begin
      // Redirect overrides stall and every normal transition. The hold
      // buffer is emptied simply by leaving S_HOLD.
      pc_d    = bus.redirect_pc_in;
      valid_d = 1'b0;
      case (state_q)
        S_REQ: begin
          if (bus.imem_gnt_in) begin
            state_d = S_WAIT;
            drop_d  = 1'b1;
          end
        end
        S_WAIT: begin
          if (bus.imem_rvalid_in) begin
            state_d = S_REQ;
            drop_d  = 1'b0;
          end else begin
            drop_d  = 1'b1;
          end
        end
        default: state_d = S_REQ;
      endcase
    end else begin
      // When decode accepts, the bundle reloads; without fresh data it is a
      // bubble and inst/pc keep their previous values.
      if (!bus.stall_in) valid_d = 1'b0;
      case (state_q)
        S_REQ: begin
          if (bus.imem_gnt_in) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (bus.imem_rvalid_in) begin
            if (drop_q) begin
              // Squashed fetch: refetch at the redirect target, no increment.
              drop_d  = 1'b0;
              state_d = S_REQ;
            end else if (!bus.stall_in) begin
              valid_d = 1'b1;
              inst_d  = bus.imem_rdata_in;
              opc_d   = pc_q;
              pc_d    = pc_q + PC_STEP;
              state_d = S_REQ;
            end else begin
              hold_inst_d = bus.imem_rdata_in;
              state_d     = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!bus.stall_in) begin
            valid_d = 1'b1;
            inst_d  = hold_inst_q;
            opc_d   = pc_q;
            pc_d    = pc_q + PC_STEP;
            state_d = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  // State register; reset abandons any outstanding fetch.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      drop_q      <= 1'b0;
      hold_inst_q <= '0;
      valid_q     <= 1'b0;
      inst_q      <= NOP;
      opc_q       <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values.
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_q      <= drop_d;
      hold_inst_q <= hold_inst_d;
      valid_q     <= valid_d;
      inst_q      <= inst_d;
      opc_q       <= opc_d;
    end
  end

  // Requests only in S_REQ, so never while the hold buffer is occupied.
  assign bus.imem_req_out  = (state_q == S_REQ);
  assign bus.imem_addr_out = pc_q;
  assign bus.if_valid_out  = valid_q;
  assign bus.if_inst_out   = inst_q;
  assign bus.if_pc_out     = opc_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage. A single process steps the clock:
// at each rising edge it samples the inputs decode/control applied, then
// 1 ns later checks the output bundle against an instruction-stream model
// (next expected PC, reset to the target on redirect); at each falling edge
// it runs the instruction-memory models and the directed/random drivers.
module tb_if_stage;

  localparam int          DW      = 32;
  localparam logic [31:0] KEY     = 32'hA5A5_0000;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  logic clk = 1'b0;
  logic arst_n;
  logic arst_w_n;

  if_stage_if #(.DATA_WIDTH(DW)) m_if ();
  if_stage_if #(.DATA_WIDTH(DW)) w_if ();

  if_stage #(.DATA_WIDTH(DW), .RESET_PC(32'h0000_0000)) u_dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (m_if)
  );

  if_stage #(.DATA_WIDTH(DW), .RESET_PC(WRAP_PC)) u_wrap (
    .clk    (clk),
    .arst_n (arst_w_n),
    .bus    (w_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      if (n_fail <= 50) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ KEY;
  endfunction

  // Main memory model state and knobs.
  bit          m_pending;
  int          m_delay;
  logic [31:0] m_paddr;
  int          gnt_mode;      // 0 always grant, 1 random, 2 never
  bit          lat_rand;
  logic [31:0] watch_addr;
  int          watch_grants;

  // Wrap-instance memory: always grants, answers the next cycle.
  bit          w_pend;
  logic [31:0] w_paddr;

  // Stream model.
  logic [31:0] exp_pc;
  int          delivered;
  logic        p_valid;
  logic [31:0] p_inst, p_pc;
  logic        c_rst, c_st, c_rd;
  logic [31:0] c_rpc;

  task automatic mem_main();
    logic g;
    if (!arst_n) begin
      m_pending              = 1'b0;
      m_if.imem_gnt_in       = 1'b0;
      m_if.imem_rvalid_in    = 1'b0;
      m_if.imem_rdata_in     = '0;
    end else begin
      if (m_pending) check("one_outstanding", 64'(m_if.imem_req_out), 64'd0);
      if (m_pending && m_delay == 0) begin
        m_if.imem_rvalid_in = 1'b1;
        m_if.imem_rdata_in  = mem_word(m_paddr);
        m_pending           = 1'b0;
      end else begin
        m_if.imem_rvalid_in = 1'b0;
        m_if.imem_rdata_in  = $urandom;
        if (m_pending) m_delay--;
      end
      g = (gnt_mode == 0) ? 1'b1 : (gnt_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
      m_if.imem_gnt_in = g;
      if (g && m_if.imem_req_out) begin
        check("addr_align", 64'(m_if.imem_addr_out[1:0]), 64'd0);
        m_pending = 1'b1;
        m_paddr   = m_if.imem_addr_out;
        m_delay   = lat_rand ? int'($urandom_range(0, 2)) : 0;
        if (m_if.imem_addr_out == watch_addr) watch_grants++;
      end
    end
  endtask

  task automatic mem_wrap();
    if (!arst_w_n) begin
      w_pend              = 1'b0;
      w_if.imem_gnt_in    = 1'b0;
      w_if.imem_rvalid_in = 1'b0;
      w_if.imem_rdata_in  = '0;
    end else begin
      w_if.imem_rvalid_in = w_pend;
      w_if.imem_rdata_in  = mem_word(w_paddr);
      w_pend              = 1'b0;
      w_if.imem_gnt_in    = 1'b1;
      if (w_if.imem_req_out) begin
        w_pend  = 1'b1;
        w_paddr = w_if.imem_addr_out;
      end
    end
  endtask

  // Compares the bundle after an edge with what the edge's inputs demand.
  task automatic monitor();
    if (c_rst) begin
      if (c_rd) begin
        check("redir_bubble", 64'(m_if.if_valid_out), 64'd0);
        exp_pc = c_rpc;
      end else if (c_st) begin
        check("stall_valid", 64'(m_if.if_valid_out), 64'(p_valid));
        check("stall_bundle", {m_if.if_inst_out, m_if.if_pc_out}, {p_inst, p_pc});
      end else if (m_if.if_valid_out) begin
        check("stream_pc", 64'(m_if.if_pc_out), 64'(exp_pc));
        check("stream_inst", 64'(m_if.if_inst_out), 64'(mem_word(exp_pc)));
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end else begin
        check("bubble_keep", {m_if.if_inst_out, m_if.if_pc_out}, {p_inst, p_pc});
      end
    end else begin
      exp_pc = 32'h0000_0000;
    end
    p_valid = m_if.if_valid_out;
    p_inst  = m_if.if_inst_out;
    p_pc    = m_if.if_pc_out;
  endtask

  task automatic step();
    @(posedge clk);
    c_rst = arst_n;
    c_st  = m_if.stall_in;
    c_rd  = m_if.redirect_in;
    c_rpc = m_if.redirect_pc_in;
    #1;
    monitor();
    @(negedge clk);
    mem_main();
    mem_wrap();
  endtask

  task automatic wait_req(input logic [31:0] a, input string tag);
    int n = 0;
    while (!(m_if.imem_req_out && m_if.imem_addr_out == a) && n < 30) begin
      step();
      n++;
    end
    check(tag, 64'(m_if.imem_req_out && m_if.imem_addr_out == a), 64'd1);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!m_if.if_valid_out && n < 30) begin
      step();
      n++;
    end
    check(tag, 64'(m_if.if_valid_out), 64'd1);
  endtask

  task automatic wait_w_valid(input string tag);
    int n = 0;
    while (!w_if.if_valid_out && n < 30) begin
      step();
      n++;
    end
    check(tag, 64'(w_if.if_valid_out), 64'd1);
  endtask

  initial begin
    int d0, g0, n;
    arst_n   = 1'b0;
    arst_w_n = 1'b0;
    m_if.stall_in = 1'b0; m_if.redirect_in = 1'b0; m_if.redirect_pc_in = '0;
    w_if.stall_in = 1'b0; w_if.redirect_in = 1'b0; w_if.redirect_pc_in = '0;
    gnt_mode = 0; lat_rand = 1'b0; watch_addr = 32'hFFFF_FFFF; watch_grants = 0;
    m_pending = 1'b0; m_delay = 0; m_paddr = '0; w_pend = 1'b0; w_paddr = '0;
    exp_pc = '0; delivered = 0; p_valid = 1'b0; p_inst = NOP; p_pc = '0;

    repeat (3) step();
    check("rst_valid", 64'(m_if.if_valid_out), 64'd0);
    check("rst_inst", 64'(m_if.if_inst_out), 64'(NOP));
    check("rst_pc", 64'(m_if.if_pc_out), 64'd0);
    check("rst_req", 64'(m_if.imem_req_out), 64'd1);
    check("rst_addr", 64'(m_if.imem_addr_out), 64'd0);

    // 1: zero-wait memory, pc 0 then 4 with one bubble between.
    arst_n = 1'b1;
    step();
    check("t1_req0", {31'd0, m_if.imem_req_out, m_if.imem_addr_out}, {31'd0, 1'b1, 32'h0});
    step();
    check("t1_n1_valid", 64'(m_if.if_valid_out), 64'd0);
    step();
    check("t1_pc0", {31'd0, m_if.if_valid_out, m_if.if_pc_out}, {31'd0, 1'b1, 32'h0});
    check("t1_inst0", 64'(m_if.if_inst_out), 64'(32'hA5A5_0000));
    step();
    check("t1_bubble", 64'(m_if.if_valid_out), 64'd0);
    step();
    check("t1_pc4", {31'd0, m_if.if_valid_out, m_if.if_pc_out}, {31'd0, 1'b1, 32'h4});
    check("t1_inst4", 64'(m_if.if_inst_out), 64'(32'hA5A5_0004));
    check("t1_req8", 64'(m_if.imem_addr_out), 64'h8);

    // 2: stall 5 cycles while fetch of 0x8 returns.
    m_if.stall_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_frozen", {31'd0, m_if.if_valid_out, m_if.if_pc_out}, {31'd0, 1'b1, 32'h4});
      check("t2_no_req", 64'(m_if.imem_req_out), 64'd0);
    end
    m_if.stall_in = 1'b0;
    step();
    check("t2_pc8", {31'd0, m_if.if_valid_out, m_if.if_pc_out}, {31'd0, 1'b1, 32'h8});
    check("t2_reqC", {31'd0, m_if.imem_req_out, m_if.imem_addr_out}, {31'd0, 1'b1, 32'hC});

    // 3: redirect to 0x100 in the grant cycle of 0x10.
    wait_req(32'h10, "t3_req10");
    m_if.redirect_in = 1'b1; m_if.redirect_pc_in = 32'h100;
    step();
    m_if.redirect_in = 1'b0;
    check("t3_bubble", 64'(m_if.if_valid_out), 64'd0);
    wait_req(32'h100, "t3_req100");
    wait_valid("t3_valid");
    check("t3_pc100", 64'(m_if.if_pc_out), 64'h100);

    // 4: redirect to 0x200 while stalled in S_HOLD.
    m_if.stall_in = 1'b1;
    repeat (3) step();
    check("t4_no_req", 64'(m_if.imem_req_out), 64'd0);
    check("t4_frozen", {31'd0, m_if.if_valid_out, m_if.if_pc_out}, {31'd0, 1'b1, 32'h100});
    m_if.redirect_in = 1'b1; m_if.redirect_pc_in = 32'h200;
    step();
    check("t4_redir_drop", 64'(m_if.if_valid_out), 64'd0);
    m_if.redirect_in = 1'b0; m_if.stall_in = 1'b0;
    wait_req(32'h200, "t4_req200");
    wait_valid("t4_valid");
    check("t4_pc200", 64'(m_if.if_pc_out), 64'h200);

    // 5: grant withheld at 0x20, redirect to 0x40 in the 2nd cycle.
    gnt_mode = 2;
    m_if.redirect_in = 1'b1; m_if.redirect_pc_in = 32'h20;
    step();
    m_if.redirect_in = 1'b0;
    wait_req(32'h20, "t5_req20");
    step();
    m_if.redirect_in = 1'b1; m_if.redirect_pc_in = 32'h40;
    watch_addr = 32'h40; g0 = watch_grants;
    step();
    m_if.redirect_in = 1'b0;
    check("t5_addr40", {31'd0, m_if.imem_req_out, m_if.imem_addr_out}, {31'd0, 1'b1, 32'h40});
    gnt_mode = 0;
    wait_valid("t5_valid");
    check("t5_pc40", 64'(m_if.if_pc_out), 64'h40);
    repeat (4) step();
    check("t5_one_grant", 64'(watch_grants - g0), 64'd1);

    // Random phase: random grant/latency/stall/redirect against the stream model.
    gnt_mode = 1; lat_rand = 1'b1; d0 = delivered;
    for (int i = 0; i < 3000; i++) begin
      m_if.stall_in    = ($urandom_range(0, 3) == 0);
      m_if.redirect_in = ($urandom_range(0, 31) == 0);
      m_if.redirect_pc_in = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8
                                                        : ($urandom & 32'hFFFF_FFFC);
      step();
    end
    m_if.stall_in = 1'b0; m_if.redirect_in = 1'b0;
    repeat (10) step();
    check("rand_progress", 64'((delivered - d0) > 100), 64'd1);

    // 6: RESET_PC = 0xFFFF_FFFC wraps to 0; async reset during S_WAIT.
    arst_w_n = 1'b1;
    wait_w_valid("t6_valid_a");
    check("t6_pc_fffc", {w_if.if_inst_out, w_if.if_pc_out}, {mem_word(WRAP_PC), WRAP_PC});
    step();
    wait_w_valid("t6_valid_b");
    check("t6_pc_wrap", {w_if.if_inst_out, w_if.if_pc_out}, {mem_word(32'h0), 32'h0});
    n = 0;
    while (w_if.imem_req_out && n < 10) begin
      step();
      n++;
    end
    check("t6_in_wait", 64'(!w_if.imem_req_out), 64'd1);
    #2 arst_w_n = 1'b0;
    #1;
    check("t6_rst_valid", 64'(w_if.if_valid_out), 64'd0);
    check("t6_rst_bundle", {w_if.if_inst_out, w_if.if_pc_out}, {NOP, 32'h0});
    check("t6_rst_req", {31'd0, w_if.imem_req_out, w_if.imem_addr_out}, {31'd0, 1'b1, WRAP_PC});
    step();
    step();
    arst_w_n = 1'b1;
    wait_w_valid("t6_valid_c");
    check("t6_restart", {w_if.if_inst_out, w_if.if_pc_out}, {mem_word(WRAP_PC), WRAP_PC});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
